clarke_pipe: RTL and testbench
==============================

Name: clarke_pipe

Overview:
Forward Clarke transform: three-phase samples a, b, c in Q_BITS fixed point go in, and stationary-frame alpha, beta come out. This is the counterpart of inverse_clarke; together they form a round trip in the FOC current path. It is a 3-stage pipeline with valid/ready handshakes on both sides, bubble collapsing, and saturation to D_WIDTH.

Parameters:
D_WIDTH, 32, signed width of every data port
Q_BITS, 10, fractional bits of the fixed-point format and of the internal constants

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  a/b/c sample valid
in_ready  out  1  block accepts a sample this cycle
a  in  D_WIDTH  phase A, signed
b  in  D_WIDTH  phase B, signed
c  in  D_WIDTH  phase C, signed
out_valid  out  1  alpha/beta valid
out_ready  in  1  downstream accepts a result this cycle
alpha  out  D_WIDTH  signed alpha, registered
beta  out  D_WIDTH  signed beta, registered

Behaviour:
- Clocking and reset: one clock (clk). rst is asynchronous and active-high.
- On rst, all three stage valid bits clear and all data registers go to 0.
  - out_valid=0, alpha=0, beta=0.
  - in_ready=1 as soon as rst deasserts.
  - Asserting rst mid-operation discards in-flight samples; no partial output is produced.
- Constants, computed at elaboration, unsigned, Q_BITS+1 bits:
  - K3 = round(2^Q_BITS/3), which is 341 at Q_BITS=10.
  - KS = round(2^Q_BITS/sqrt(3)), which is 591 at Q_BITS=10.
- Stage 1 (S1), differences, D_WIDTH+2 bits signed, no overflow possible:
  - dA = 2a - b - c
  - dB = b - c
- Stage 2 (S2), products, D_WIDTH+Q_BITS+3 bits signed:
  - pA = dA*K3
  - pB = dB*KS
- Stage 3 (S3), round half-up, shift, saturate, then register into alpha/beta:
  - r = (p + 2^(Q_BITS-1)) >>> Q_BITS, arithmetic shift.
  - If r > 2^(D_WIDTH-1)-1, output 2^(D_WIDTH-1)-1.
  - If r < -2^(D_WIDTH-1), output -2^(D_WIDTH-1).
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_valid is the S3 valid bit; alpha and beta hold stable while out_valid && !out_ready.
  - Data does not change without a transfer.
- Advance rules (bubble collapsing):
  - adv3 = !v3 || out_ready
  - adv2 = !v2 || adv3
  - adv1 = !v1 || adv2
  - in_ready = adv1, combinational from valid bits and out_ready only. It never depends on in_valid.
- Latency and throughput:
  - Latency is 3 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 sample/cycle while out_ready=1.
  - Capacity is 3 samples. in_ready drops only when all three stages are valid and out_ready=0.
- Simultaneous events: on a full pipe with out_ready=1, the output transfer, all stage shifts, and a new input transfer happen in the same cycle.
- Ordering: output order equals input order; no sample is dropped or duplicated.

Optional Feature:
CLARKE_ZERO_SEQ_EN
- Defined:
  - Adds port "gamma  out  D_WIDTH" for the zero-sequence component, gamma = (a+b+c)*K3 with the same round/shift/saturate.
  - gamma is pipelined alongside alpha and beta, and is reset to 0.
  - gamma obeys the same hold-under-stall rule.
- Undefined: the port and its logic are absent, and the ports and timing are otherwise identical.

Decomposition:
- Package clarke_pkg holds:
  - the elaboration-time constant functions for K3 and KS given Q_BITS;
  - the round/shift/saturate function, parameterised by input width.
- Sub-module clarke_pipe_stage: one valid+data register with an adv input. It is instantiated three times, one per stage, with widths set per stage.

Test Plan:
- Reset with out_ready=1: out_valid=0, alpha=beta=0, in_ready=1 during rst and on the first cycle after it deasserts.
- Single sample a=40, b=-20, c=-20: out_valid exactly 3 cycles later, alpha=40, beta=0.
- Back-to-back samples (0,32,-32) then (-32,-32,64):
  - Consecutive outputs (alpha 0, beta 37) then (alpha -32, beta -55).
  - out_valid high two consecutive cycles.
- Backpressure with out_ready=0 and 4 samples offered:
  - in_ready falls after the 3rd accept; alpha/beta stay frozen.
  - Releasing out_ready drains all 4 in order with no loss or duplicate.
- Saturation: a=2^31-1, b=c=-2^31 gives alpha=2147483647; a=0, b=-2^31, c=2^31-1 gives beta=-2147483648.
- Reset mid-flight: rst asserted with 2 samples in the pipe; out_valid=0 immediately (asynchronous); no stale output after rst deasserts.
- With CLARKE_ZERO_SEQ_EN defined: a=b=c=30 gives gamma=30, alpha=0, beta=0.

Source files
------------

// File: rtl/clarke_pkg.sv
// Shared constants and arithmetic helpers for the forward Clarke pipeline.
// Optional zero-sequence output is enabled with the CLARKE_ZERO_SEQ_EN macro.
package clarke_pkg;

    localparam int RS_W = 128;

    // round(2^qb / 3) == floor((2^(qb+1) + 3) / 6)
    function automatic int k3_const(input int qb);
        longint n;
        n = (longint'(1) <<< (qb + 1)) + 3;
        return int'(n / 6);
    endfunction

    // round(2^qb / sqrt(3)): largest n with 3*(2n-1)^2 <= 4^(qb+1), found by bisection
    function automatic int ks_const(input int qb);
        longint lim;
        longint lo;
        longint hi;
        longint mid;
        lim = longint'(1) <<< (2 * qb + 2);
        lo  = 0;
        hi  = longint'(1) <<< qb;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (3 * (2 * mid - 1) * (2 * mid - 1) <= lim) begin
                lo = mid;
            end else begin
                hi = mid - 1;
            end
        end
        return int'(lo);
    endfunction

    // Interprets the low pw bits of p_raw as signed, rounds half-up by qb bits
    // and clamps to the signed dw-bit range.
    function automatic logic signed [RS_W-1:0] round_sat(
        input logic [RS_W-1:0] p_raw,
        input int              pw,
        input int              qb,
        input int              dw
    );
        logic signed [RS_W-1:0] p;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        logic signed [RS_W-1:0] one;
        one = {{(RS_W-1){1'b0}}, 1'b1};
        p   = p_raw << (RS_W - pw);
        p   = p >>> (RS_W - pw);
        r   = (p + (one <<< (qb - 1))) >>> qb;
        hi  = (one <<< (dw - 1)) - one;
        lo  = -(one <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/clarke_pipe_stage.sv
// One pipeline slot: a valid bit plus a data word, advanced by adv_i.
// Data only loads on an actual transfer so outputs never change spuriously.
module clarke_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/clarke_pipe.sv
// Forward Clarke transform, 3-stage valid/ready pipeline with bubble collapsing.
// Define CLARKE_ZERO_SEQ_EN to add the gamma (zero-sequence) output channel.
module clarke_pipe
    import clarke_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    input  logic [D_WIDTH-1:0] c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] alpha,
    output logic [D_WIDTH-1:0] beta
`ifdef CLARKE_ZERO_SEQ_EN
    ,
    output logic [D_WIDTH-1:0] gamma
`endif
);

`ifdef CLARKE_ZERO_SEQ_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int DW   = D_WIDTH + 2;
    localparam int PW   = D_WIDTH + Q_BITS + 3;
    localparam int K3_I = k3_const(Q_BITS);
    localparam int KS_I = ks_const(Q_BITS);
    localparam logic [Q_BITS:0] K3 = K3_I[Q_BITS:0];
    localparam logic [Q_BITS:0] KS = KS_I[Q_BITS:0];

    logic adv1;
    logic adv2;
    logic adv3;
    logic v1;
    logic v2;
    logic v3;

    logic [NCH*DW-1:0]      s1_d;
    logic [NCH*DW-1:0]      s1_q;
    logic [NCH*PW-1:0]      s2_d;
    logic [NCH*PW-1:0]      s2_q;
    logic [NCH*D_WIDTH-1:0] s3_d;
    logic [NCH*D_WIDTH-1:0] s3_q;

    logic signed [DW-1:0] a_x;
    logic signed [DW-1:0] b_x;
    logic signed [DW-1:0] c_x;

    assign adv3     = !v3 || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    assign a_x = $signed({{2{a[D_WIDTH-1]}}, a});
    assign b_x = $signed({{2{b[D_WIDTH-1]}}, b});
    assign c_x = $signed({{2{c[D_WIDTH-1]}}, c});

    // Channel order in every stage word: 0 = alpha, 1 = beta, 2 = gamma.
    assign s1_d[0 +: DW]  = (a_x <<< 1) - b_x - c_x;
    assign s1_d[DW +: DW] = b_x - c_x;
`ifdef CLARKE_ZERO_SEQ_EN
    assign s1_d[2*DW +: DW] = a_x + b_x + c_x;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [Q_BITS:0] KK = (gi == 1) ? KS : K3;
            logic signed [DW-1:0] d_s;
            logic signed [PW-1:0] d_ext;
            logic signed [PW-1:0] k_ext;

            assign d_s   = s1_q[gi*DW +: DW];
            assign d_ext = {{(PW-DW){d_s[DW-1]}}, d_s};
            assign k_ext = {{(PW-Q_BITS-1){1'b0}}, KK};
            assign s2_d[gi*PW +: PW] = d_ext * k_ext;

            assign s3_d[gi*D_WIDTH +: D_WIDTH] =
                D_WIDTH'(round_sat(RS_W'(s2_q[gi*PW +: PW]), PW, Q_BITS, D_WIDTH));
        end
    endgenerate

    clarke_pipe_stage #(.W(NCH*DW)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (adv1),
        .valid_i (in_valid),
        .data_i  (s1_d),
        .valid_o (v1),
        .data_o  (s1_q)
    );

    clarke_pipe_stage #(.W(NCH*PW)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (adv2),
        .valid_i (v1),
        .data_i  (s2_d),
        .valid_o (v2),
        .data_o  (s2_q)
    );

    clarke_pipe_stage #(.W(NCH*D_WIDTH)) u_s3 (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (adv3),
        .valid_i (v2),
        .data_i  (s3_d),
        .valid_o (v3),
        .data_o  (s3_q)
    );

    assign out_valid = v3;
    assign alpha     = s3_q[0 +: D_WIDTH];
    assign beta      = s3_q[D_WIDTH +: D_WIDTH];
`ifdef CLARKE_ZERO_SEQ_EN
    assign gamma     = s3_q[2*D_WIDTH +: D_WIDTH];
`endif

endmodule

// File: tb/tb_clarke_pipe.sv
// Self-checking bench for clarke_pipe: directed cases plus randomized traffic
// against an integer-arithmetic model. Honours CLARKE_ZERO_SEQ_EN when defined.
module tb_clarke_pipe;

    localparam int QB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] c = '0;
    logic [31:0] alpha;
    logic [31:0] beta;
`ifdef CLARKE_ZERO_SEQ_EN
    logic [31:0] gamma;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint al;
        longint be;
        longint ga;
    } res_t;

    res_t   exp_q[$];
    longint obs_a[$];
    longint obs_b[$];
    longint obs_g[$];
    longint k3_m;
    longint ks_m;
    res_t   mon_e;

    clarke_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alpha     (alpha),
        .beta      (beta)
`ifdef CLARKE_ZERO_SEQ_EN
        ,
        .gamma     (gamma)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint sat32(input longint r);
        if (r > 64'sd2147483647) return 64'sd2147483647;
        if (r < -64'sd2147483648) return -64'sd2147483648;
        return r;
    endfunction

    function automatic longint rnd_shift(input longint p);
        return sat32(fdiv(p + (longint'(1) << (QB - 1)), longint'(1) << QB));
    endfunction

    function automatic res_t model(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc);
        res_t   r;
        longint sa;
        longint sb;
        longint sc;
        sa   = longint'($signed(aa));
        sb   = longint'($signed(bb));
        sc   = longint'($signed(cc));
        r.al = rnd_shift((2 * sa - sb - sc) * k3_m);
        r.be = rnd_shift((sb - sc) * ks_m);
        r.ga = rnd_shift((sa + sb + sc) * k3_m);
        return r;
    endfunction

    function automatic longint obs_at(input int which, input int idx);
        if (idx >= obs_a.size()) return 64'sd99999999999;
        if (which == 0) return obs_a[idx];
        if (which == 1) return obs_b[idx];
        return obs_g[idx];
    endfunction

    function automatic int rnd_val();
        if ($urandom_range(0, 1) == 1) return int'($urandom);
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // Scoreboard: record every input transfer, compare every output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(model(a, b, c));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else if (out_ready) begin
                    mon_e = exp_q.pop_front();
                    check("alpha", longint'($signed(alpha)), mon_e.al);
                    check("beta", longint'($signed(beta)), mon_e.be);
                    obs_a.push_back(longint'($signed(alpha)));
                    obs_b.push_back(longint'($signed(beta)));
`ifdef CLARKE_ZERO_SEQ_EN
                    check("gamma", longint'($signed(gamma)), mon_e.ga);
                    obs_g.push_back(longint'($signed(gamma)));
                    $display("[TB] out alpha=%0d beta=%0d gamma=%0d", $signed(alpha), $signed(beta), $signed(gamma));
`else
                    obs_g.push_back(0);
                    $display("[TB] out alpha=%0d beta=%0d", $signed(alpha), $signed(beta));
`endif
                end else begin
                    check("hold_alpha", longint'($signed(alpha)), exp_q[0].al);
                    check("hold_beta", longint'($signed(beta)), exp_q[0].be);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input int aa, input int bb, input int cc);
        int t;
        a        = aa;
        b        = bb;
        c        = cc;
        in_valid = 1'b1;
        t        = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", longint'(exp_q.size()), 0);
        check("drain_idle", longint'(out_valid), 0);
        @(posedge clk);
        #1;
    endtask

    int   n;
    int   base;
    int   sent;
    int   cyc;
    logic acc;
    int   bp_a[4] = '{100, 7, -300, 1000};
    int   bp_b[4] = '{-50, 8, 100, -1000};
    int   bp_c[4] = '{-50, 9, 200, 0};
    res_t r0;

    initial begin
        k3_m = longint'($rtoi((2.0 ** QB) / 3.0 + 0.5));
        ks_m = longint'($rtoi((2.0 ** QB) / $sqrt(3.0) + 0.5));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_alpha", longint'(alpha), 0);
        check("rst_beta", longint'(beta), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(in_ready), 1);
        check("post_rst_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;

        // Single sample and latency
        base = obs_a.size();
        send(40, -20, -20);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check("latency", longint'(n), 3);
        @(posedge clk);
        #1;
        wait_drain();
        check("single_alpha", obs_at(0, base), 40);
        check("single_beta", obs_at(1, base), 0);

        // Back-to-back
        base = obs_a.size();
        send(0, 32, -32);
        send(-32, -32, 64);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check("b2b_valid1", longint'(out_valid), 1);
        @(negedge clk);
        check("b2b_valid2", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        wait_drain();
        check("b2b_alpha0", obs_at(0, base), 0);
        check("b2b_beta0", obs_at(1, base), 37);
        check("b2b_alpha1", obs_at(0, base + 1), -32);
        check("b2b_beta1", obs_at(1, base + 1), -55);

        // Backpressure: pipe holds three, fourth waits
        base      = obs_a.size();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(bp_a[i], bp_b[i], bp_c[i]);
        r0       = model(bp_a[0], bp_b[0], bp_c[0]);
        a        = bp_a[3];
        b        = bp_b[3];
        c        = bp_c[3];
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_frozen_alpha", longint'($signed(alpha)), r0.al);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();
        check("bp_count", longint'(obs_a.size() - base), 4);
        for (int i = 0; i < 4; i++) begin
            r0 = model(bp_a[i], bp_b[i], bp_c[i]);
            check("bp_order_alpha", obs_at(0, base + i), r0.al);
            check("bp_order_beta", obs_at(1, base + i), r0.be);
        end

        // Saturation
        base = obs_a.size();
        send(int'(32'h7fff_ffff), int'(32'h8000_0000), int'(32'h8000_0000));
        send(0, int'(32'h8000_0000), int'(32'h7fff_ffff));
        wait_drain();
        check("sat_alpha_hi", obs_at(0, base), 64'sd2147483647);
        check("sat_beta_lo", obs_at(1, base + 1), -64'sd2147483648);

`ifdef CLARKE_ZERO_SEQ_EN
        base = obs_a.size();
        send(30, 30, 30);
        wait_drain();
        check("zs_gamma", obs_at(2, base), 30);
        check("zs_alpha", obs_at(0, base), 0);
        check("zs_beta", obs_at(1, base), 0);
`endif

        // Reset with samples in flight
        out_ready = 1'b0;
        send(5, 5, -10);
        send(11, -3, -8);
        @(posedge clk);
        #2;
        check("pre_rst_valid", longint'(out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", longint'(out_valid), 0);
        check("async_rst_alpha", longint'(alpha), 0);
        check("async_rst_in_ready", longint'(in_ready), 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("no_stale_out", longint'(n), 0);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        sent = 0;
        acc  = 1'b0;
        cyc  = 0;
        while ((sent < 400 || in_valid) && cyc < 20000) begin
            if (acc) sent++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                if (sent < 400 && $urandom_range(0, 4) != 0) begin
                    in_valid = 1'b1;
                    a = rnd_val();
                    b = rnd_val();
                    c = rnd_val();
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rand_sent", longint'(sent), 400);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
